// File: rtl/h264_bs_axis_packer.sv
// rtl/h264_bs_axis_packer.sv - packs h264_core bytes into AXI4-Stream beats through an overflow-reporting FWFT FIFO
module h264_bs_axis_packer #(
  parameter int OUT_BYTES  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           byte_valid_i,
  input  logic [7:0]                     byte_data_i,
  input  logic                           frame_done_i,
  output logic [8*OUT_BYTES-1:0]         tdata_o,
  output logic [OUT_BYTES-1:0]           tkeep_o,
  output logic                           tvalid_o,
  output logic                           tlast_o,
  input  logic                           tready_i,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o,
  output logic                           overflow_o,
  output logic [CNT_W-1:0]               drop_cnt_o,
  output logic [CNT_W-1:0]               frame_cnt_o
);

  localparam int IDX_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DW    = 8 * OUT_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_BYTES - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [IDX_W-1:0]     idx_q;
  logic [DW-1:0]        word_q, word_nxt;
  logic [OUT_BYTES-1:0] keep_q, keep_nxt;
  logic                 push;

  // Lanes not yet written stay zero because the word is cleared on every push.
  always_comb begin
    word_nxt = word_q;
    keep_nxt = keep_q;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        word_nxt[8*i +: 8] = byte_data_i;
        keep_nxt[i]        = 1'b1;
      end
    end
  end

  assign push = byte_valid_i & ((idx_q == LAST_IDX) | frame_done_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
      keep_q <= '0;
    end else if (byte_valid_i) begin
      if (push) begin
        idx_q  <= '0;
        word_q <= '0;
        keep_q <= '0;
      end else begin
        idx_q  <= idx_q + 1'b1;
        word_q <= word_nxt;
        keep_q <= keep_nxt;
      end
    end
  end

  logic [DW-1:0]        mem_data [FIFO_DEPTH];
  logic [OUT_BYTES-1:0] mem_keep [FIFO_DEPTH];
  logic                 mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level_q;
  logic                 pop, full, wr_en, drop;

  assign tvalid_o = (level_q != '0);
  assign pop      = tvalid_o & tready_i;
  assign full     = (level_q == FULL_LVL);
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign wr_en    = push & (~full | pop);
  assign drop     = push & full & ~pop;

  assign tdata_o      = tvalid_o ? mem_data[rd_ptr] : '0;
  assign tkeep_o      = tvalid_o ? mem_keep[rd_ptr] : '0;
  assign tlast_o      = tvalid_o & mem_last[rd_ptr];
  assign fifo_level_o = level_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= word_nxt;
      mem_keep[wr_ptr] <= keep_nxt;
      mem_last[wr_ptr] <= frame_done_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_o  <= 1'b0;
      drop_cnt_o  <= '0;
      frame_cnt_o <= '0;
    end else begin
      if (byte_valid_i & frame_done_i) frame_cnt_o <= frame_cnt_o + 1'b1;
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

endmodule
